// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl: serial unsigned magnitude comparator built around a single
// 4-bit compare slice. It walks the latched operands MSB nibble first and stops
// at the first nibble that differs. If every nibble is equal, the latched
// cascade inputs (IGT/ILE/IEQ) decide the result. Handshake is start/busy/done.
module compare_seq_ctrl #(
  parameter int WIDTH = 16  // operand width; must be a multiple of 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IGT,
  input  logic             ILE,
  input  logic             IEQ,
  output logic             busy,
  output logic             done,
  output logic             FGT,
  output logic             FLE,
  output logic             FEQ
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             igt_q, ile_q, ieq_q;
  logic [IW-1:0]    idx, idx_nxt;

  logic             load;
  logic             res_en;
  logic             fgt_nxt, fle_nxt, feq_nxt;
  logic [3:0]       a_nib, b_nib;

  // Select the nibble currently being examined by the shared compare slice.
  assign a_nib = a_q[{idx, 2'b00} +: 4];
  assign b_nib = b_q[{idx, 2'b00} +: 4];

  // Next-state, nibble index and result decode for the serial scan.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    res_en    = 1'b0;
    fgt_nxt   = 1'b0;
    fle_nxt   = 1'b0;
    feq_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          idx_nxt   = IW'(NIB - 1);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (a_nib > b_nib) begin
          res_en    = 1'b1;
          fgt_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (a_nib < b_nib) begin
          res_en    = 1'b1;
          fle_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (idx != '0) begin
          idx_nxt = idx - IW'(1);
        end else begin
          // All nibbles equal: the cascade bits decide. IEQ dominates; without
          // it, IGT/ILE pass straight through, including the 0/0 and 1/1 cases.
          res_en    = 1'b1;
          feq_nxt   = ieq_q;
          fgt_nxt   = ~ieq_q & igt_q;
          fle_nxt   = ~ieq_q & ile_q;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched operands, registered handshake and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand copies are plain registers, not a memory, so they
      // are cleared with everything else and never hold stale data after reset.
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      igt_q <= 1'b0;
      ile_q <= 1'b0;
      ieq_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      FGT   <= 1'b0;
      FLE   <= 1'b0;
      FEQ   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (load) begin
        a_q   <= A;
        b_q   <= B;
        igt_q <= IGT;
        ile_q <= ILE;
        ieq_q <= IEQ;
      end
      if (res_en) begin
        FGT <= fgt_nxt;
        FLE <= fle_nxt;
        FEQ <= feq_nxt;
      end
    end
  end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// tb_compare_seq_ctrl: directed vectors with hand-computed results and
// latencies for the serial magnitude comparator.
module tb_compare_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        IGT;
  logic        ILE;
  logic        IEQ;
  logic        busy;
  logic        done;
  logic        FGT;
  logic        FLE;
  logic        FEQ;

  int n_vec  = 0;
  int n_miss = 0;

  compare_seq_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .IGT   (IGT),
    .ILE   (ILE),
    .IEQ   (IEQ),
    .busy  (busy),
    .done  (done),
    .FGT   (FGT),
    .FLE   (FLE),
    .FEQ   (FEQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one compare starting at a negedge while the DUT is idle. Returns at
  // the negedge of the idle cycle that follows done, so a caller may chain.
  task automatic do_compare(input string tag,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic igt, input logic ile, input logic ieq,
                            input int exp_lat, input logic [2:0] exp_flags,
                            input bit pulse_again);
    int n;
    A = a; B = b; IGT = igt; ILE = ile; IEQ = ieq;
    start = 1'b1;
    @(negedge clk);
    // Operands change after acceptance; only the latched copies may matter.
    start = 1'b0;
    A = ~a; B = ~b; IGT = ~igt; ILE = ~ile; IEQ = ~ieq;
    n = 1;
    check({tag, "_busy_scan"}, {31'd0, busy}, 32'd1);
    while (!done && n < 12) begin
      if (pulse_again && n == 1) begin
        start = 1'b1;
        A = 16'h0000; B = 16'hFFFF; IEQ = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    end else begin
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      check({tag, "_flags"}, {29'd0, FGT, FLE, FEQ}, {29'd0, exp_flags});
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
      check({tag, "_flags_hold"}, {29'd0, FGT, FLE, FEQ}, {29'd0, exp_flags});
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; IGT = 1'b0; ILE = 1'b0; IEQ = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, FGT, FLE, FEQ}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {27'd0, busy, done, FGT, FLE, FEQ}, 32'd0);

    // Flags are {FGT, FLE, FEQ}.
    do_compare("msb_gt",    16'h1234, 16'h0234, 1'b0, 1'b0, 1'b1, 2, 3'b100, 1'b0);
    do_compare("lsb_lt",    16'hABCD, 16'hABCE, 1'b0, 1'b0, 1'b1, 5, 3'b010, 1'b0);
    do_compare("nib1_lt",   16'h00A0, 16'h00B0, 1'b0, 1'b0, 1'b1, 4, 3'b010, 1'b0);
    do_compare("unsigned",  16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 1'b0, 2, 3'b100, 1'b0);
    do_compare("eq_ieq",    16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b1, 5, 3'b001, 1'b0);
    do_compare("eq_ieq_gt", 16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b1, 5, 3'b001, 1'b0);
    do_compare("eq_igt",    16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b0, 5, 3'b100, 1'b0);
    do_compare("eq_ile",    16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b0, 5, 3'b010, 1'b0);
    do_compare("eq_00",     16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 5, 3'b000, 1'b0);
    do_compare("eq_11",     16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 5, 3'b110, 1'b0);

    // start while busy must be ignored: same result and latency, no second run.
    do_compare("busy_start", 16'h0F00, 16'h0E00, 1'b0, 1'b0, 1'b1, 3, 3'b100, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no_queued_compare", seen, 0);

    // Reset in the second SCAN cycle aborts with no done pulse.
    A = 16'h1234; B = 16'h1235; IGT = 1'b0; ILE = 1'b0; IEQ = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", {27'd0, busy, done, FGT, FLE, FEQ}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no_done_after_abort", seen, 0);
    do_compare("after_abort", 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1, 5, 3'b010, 1'b0);

    // Back-to-back: second start issued in the idle cycle right after done.
    do_compare("b2b_first",  16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 2, 3'b100, 1'b0);
    do_compare("b2b_second", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 5, 3'b010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
